// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

   localparam int REG_W = 5;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // A source matches a destination only when it is a real register (r0 never forwards or stalls).
   function automatic logic reg_hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
      return (src != '0) && (src == dst);
   endfunction

endpackage

// File: rtl/pipe_fwd.sv
// Purely combinational forwarding comparators for the Execute ALU and the Decode branch comparator.
module pipe_fwd
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] rs_d_i,
   input  logic [REG_W-1:0] rt_d_i,
   input  logic [REG_W-1:0] rs_e_i,
   input  logic [REG_W-1:0] rt_e_i,
   input  logic [REG_W-1:0] write_reg_m_i,
   input  logic [REG_W-1:0] write_reg_w_i,
   input  logic             reg_write_m_i,
   input  logic             reg_write_w_i,
   output logic [1:0]       forward_ae_o,
   output logic [1:0]       forward_be_o,
   output logic             forward_ad_o,
   output logic             forward_bd_o
);

   // Memory stage holds the younger result, so it takes priority over writeback.
   always_comb begin
      forward_ae_o = FWD_RF;
      if (reg_write_m_i && reg_hit(rs_e_i, write_reg_m_i)) begin
         forward_ae_o = FWD_M;
      end else if (reg_write_w_i && reg_hit(rs_e_i, write_reg_w_i)) begin
         forward_ae_o = FWD_W;
      end

      forward_be_o = FWD_RF;
      if (reg_write_m_i && reg_hit(rt_e_i, write_reg_m_i)) begin
         forward_be_o = FWD_M;
      end else if (reg_write_w_i && reg_hit(rt_e_i, write_reg_w_i)) begin
         forward_be_o = FWD_W;
      end
   end

   assign forward_ad_o = reg_write_m_i && reg_hit(rs_d_i, write_reg_m_i);
   assign forward_bd_o = reg_write_m_i && reg_hit(rt_d_i, write_reg_m_i);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch stalls, and a multi-cycle mul/div occupancy FSM.
// Optional stall performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] RsD,
   input  logic [REG_W-1:0] RtD,
   input  logic [REG_W-1:0] RsE,
   input  logic [REG_W-1:0] RtE,
   input  logic [REG_W-1:0] WriteRegE,
   input  logic [REG_W-1:0] WriteRegM,
   input  logic [REG_W-1:0] WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             PCSrcD,
   input  logic             MdStartE,
   input  logic             MdIsDivE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             MdBusy,
   output logic             MdDone
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]      StallCnt
`endif
);

   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES);

   md_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       md_done;

   logic [1:0] fwd_ae, fwd_be;
   logic       fwd_ad, fwd_bd;
   logic       lwstall, brstall, hazard_stall, stall;

   pipe_fwd u_fwd (
      .rs_d_i        (RsD),
      .rt_d_i        (RtD),
      .rs_e_i        (RsE),
      .rt_e_i        (RtE),
      .write_reg_m_i (WriteRegM),
      .write_reg_w_i (WriteRegW),
      .reg_write_m_i (RegWriteM),
      .reg_write_w_i (RegWriteW),
      .forward_ae_o  (fwd_ae),
      .forward_be_o  (fwd_be),
      .forward_ad_o  (fwd_ad),
      .forward_bd_o  (fwd_bd)
   );

   assign lwstall = MemtoRegE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE));
   assign brstall = BranchD &&
                    ((RegWriteE && (reg_hit(RsD, WriteRegE) || reg_hit(RtD, WriteRegE))) ||
                     (MemtoRegM && (reg_hit(RsD, WriteRegM) || reg_hit(RtD, WriteRegM))));
   assign hazard_stall = lwstall || brstall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // MdStartE is only honoured in RUN; in MD_BUSY Execute carries a bubble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      md_done = 1'b0;
      case (state_q)
         RUN: begin
            if (MdStartE) begin
               state_d = MD_BUSY;
               cnt_d   = MdIsDivE ? DIV_LOAD : MUL_LOAD;
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = RUN;
               md_done = 1'b1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Reset forces every pipeline control quiet, independent of the hazard inputs.
   assign stall     = !rst && ((state_q == MD_BUSY) || hazard_stall);
   assign StallF    = stall;
   assign StallD    = stall;
   assign FlushE    = stall;
   assign FlushD    = !rst && (state_q == RUN) && PCSrcD && !stall;
   assign ForwardAE = rst ? FWD_RF : fwd_ae;
   assign ForwardBE = rst ? FWD_RF : fwd_be;
   assign ForwardAD = !rst && fwd_ad;
   assign ForwardBD = !rst && fwd_bd;
   assign MdBusy    = (state_q == MD_BUSY);
   assign MdDone    = md_done;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt_d = stall_cnt_q + 32'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
      end else if (stall) begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: reference model feeds an expected-output queue each driven cycle.
module tb_pipe_ctrl;

  localparam int W = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] RsD = '0, RtD = '0, RsE = '0, RtE = '0;
  logic [4:0] WriteRegE = '0, WriteRegM = '0, WriteRegW = '0;
  logic       RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic       MemtoRegE = 1'b0, MemtoRegM = 1'b0;
  logic       BranchD = 1'b0, PCSrcD = 1'b0, MdStartE = 1'b0, MdIsDivE = 1'b0;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, MdBusy, MdDone;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] StallCnt;
`endif

  // clock / reset
  always #5 clk = ~clk;

  pipe_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .MdStartE(MdStartE), .MdIsDivE(MdIsDivE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MdBusy(MdBusy), .MdDone(MdDone)
`ifdef PIPE_CTRL_PERF_EN
    , .StallCnt(StallCnt)
`endif
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
                    ForwardAD, ForwardBD, MdBusy, MdDone};

  // reference model: remaining mul/div cycles and stall count
  int          mdl_left = 0;
  logic [31:0] mdl_stalls = '0;

  function automatic logic hit(input logic [4:0] s, input logic [4:0] d);
    return (s != 5'd0) && (s == d);
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [1:0] fae, fbe;
    logic fad, fbd, lw, br, busy, done, st, fd;
    if (rst) return '0;
    if (RegWriteM && hit(RsE, WriteRegM)) fae = 2'b10;
    else if (RegWriteW && hit(RsE, WriteRegW)) fae = 2'b01;
    else fae = 2'b00;
    if (RegWriteM && hit(RtE, WriteRegM)) fbe = 2'b10;
    else if (RegWriteW && hit(RtE, WriteRegW)) fbe = 2'b01;
    else fbe = 2'b00;
    fad = RegWriteM && hit(RsD, WriteRegM);
    fbd = RegWriteM && hit(RtD, WriteRegM);
    lw = MemtoRegE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE));
    br = BranchD && ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                     (MemtoRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
    busy = (mdl_left != 0);
    done = (mdl_left == 1);
    if (busy) begin
      st = 1'b1;
      fd = 1'b0;
    end else begin
      st = lw || br;
      fd = PCSrcD && !st;
    end
    return {st, st, fd, st, fae, fbe, fad, fbd, busy, done};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_left   <= 0;
      mdl_stalls <= '0;
    end else begin
      if (model_out() & 12'h400) mdl_stalls <= mdl_stalls + 32'd1;
      if (mdl_left > 0) mdl_left <= mdl_left - 1;
      else if (MdStartE) mdl_left <= MdIsDivE ? 32 : 4;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver: called at posedge+1 after inputs are set; checks and advances to next posedge+1
  task automatic check_now(input string tag);
    logic [W-1:0] e;
    exp_q.push_back(model_out());
    #3;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(dut_vec), 32'(e));
    end
`ifdef PIPE_CTRL_PERF_EN
    check_eq({tag, "_cnt"}, StallCnt, mdl_stalls);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
    {BranchD, PCSrcD, MdStartE, MdIsDivE} = '0;
  endtask

  task automatic rand_inputs(input bit allow_md);
    RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
    RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
    WriteRegE = 5'($urandom_range(0, 3));
    WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
    MemtoRegM = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
    PCSrcD = 1'($urandom_range(0, 1));
    MdStartE = allow_md ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
    MdIsDivE = 1'($urandom_range(0, 1));
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset quiets everything even with forwarding/stall inputs present
    RsE = 5; WriteRegM = 5; RegWriteM = 1; MemtoRegE = 1; WriteRegE = 8; RtD = 8; PCSrcD = 1;
    check_now("rst_quiet");
    rst = 1'b0;
    clr_inputs();

    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    check_now("fwd_ae_m");
    RsE = 0;
    check_now("fwd_ae_r0");
    clr_inputs();
    RtE = 7; WriteRegW = 7; RegWriteW = 1; WriteRegM = 3; RegWriteM = 1; RsD = 3; RtD = 3;
    check_now("fwd_be_w_ad_bd");

    clr_inputs();
    MemtoRegE = 1; WriteRegE = 8; RegWriteE = 1; RtD = 8;
    check_now("lw_stall");
    MemtoRegE = 0; RegWriteE = 0; MemtoRegM = 1; WriteRegM = 8; RegWriteM = 1;
    check_now("lw_released");
    clr_inputs();
    MemtoRegE = 1; WriteRegE = 0;
    check_now("lw_r0_ignored");

    clr_inputs();
    BranchD = 1; PCSrcD = 1; RsD = 3; RtD = 4;
    check_now("br_flush");
    RegWriteE = 1; WriteRegE = 3;
    check_now("br_stall_e");
    RegWriteE = 0; MemtoRegM = 1; WriteRegM = 4;
    check_now("br_stall_m");

    // multiply with a simultaneous load-use stall and taken branch
    clr_inputs();
    MdStartE = 1; MdIsDivE = 0; MemtoRegE = 1; WriteRegE = 2; RsD = 2; PCSrcD = 1;
    check_now("mul_start_stall");
    for (int i = 1; i <= 4; i++) begin
      rand_inputs(1'b0);
      check_now($sformatf("mul_busy_%0d", i));
    end
    clr_inputs();
    check_now("mul_run");

    MdStartE = 1; MdIsDivE = 1;
    check_now("div_start");
    for (int i = 1; i <= 32; i++) begin
      rand_inputs(1'b0);
      check_now($sformatf("div_busy_%0d", i));
    end
    clr_inputs();
    check_now("div_run");

    // reset in the 10th busy cycle of a divide
    MdStartE = 1; MdIsDivE = 1;
    check_now("div2_start");
    MdStartE = 0;
    for (int i = 1; i <= 9; i++) check_now($sformatf("div2_busy_%0d", i));
    rst = 1'b1;
    MemtoRegE = 1; WriteRegE = 6; RtD = 6;
    check_now("rst_mid_div");
    rst = 1'b0;
    clr_inputs();
    for (int i = 0; i < 4; i++) check_now($sformatf("post_rst_%0d", i));

    for (int i = 0; i < 300; i++) begin
      rand_inputs(1'b1);
      check_now($sformatf("rand_%0d", i));
    end

`ifdef PIPE_CTRL_PERF_EN
    rst = 1'b1;
    clr_inputs();
    check_now("perf_rst");
    rst = 1'b0;
    MdStartE = 1; MdIsDivE = 1;
    check_now("perf_div");
    MdStartE = 0;
    for (int i = 0; i < 32; i++) check_now($sformatf("perf_busy_%0d", i));
    MemtoRegE = 1; WriteRegE = 9; RsD = 9;
    check_now("perf_lw");
    clr_inputs();
    #3;
    check_eq("perf_total", StallCnt, 32'd33);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 4, giving the multiply occupancy in cycles (legal range 1..255).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 32, giving the divide occupancy in cycles (legal range 1..255).
REQ-003 clk  in  1  the one clock; all state updates on the posedge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 RsD, RtD  in  5 each  source registers of the instruction in Decode.
REQ-006 RsE, RtE  in  5 each  source registers of the instruction in Execute.
REQ-007 WriteRegE, WriteRegM, WriteRegW  in  5 each  destination registers.
REQ-008 RegWriteE, RegWriteM, RegWriteW  in  1 each  destination-write enables.
REQ-009 MemtoRegE, MemtoRegM  in  1 each  the instruction is a load.
REQ-010 BranchD  in  1  a branch is in Decode; PCSrcD  in  1  the branch is taken.
REQ-011 MdStartE  in  1  mul/div in Execute; MdIsDivE  in  1  1 = divide, 0 = multiply.
REQ-012 StallF, StallD  out  1 each  hold PC / IF-ID register (IF-ID en = ~StallD).
REQ-013 FlushD, FlushE  out  1 each  synchronous clear of IF-ID / ID-EX registers.
REQ-014 ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = from W, 10 = from M.
REQ-015 ForwardAD, ForwardBD  out  1 each  forward M result to the Decode comparator.
REQ-016 MdBusy  out  1  the multi-cycle unit is occupied; MdDone  out  1  one-cycle completion pulse.

Function
REQ-017 ForwardAE SHALL be 10 when RsE!=0, RegWriteM=1 and RsE==WriteRegM; else 01 when RsE!=0, RegWriteW=1 and RsE==WriteRegW; else 00 (M wins over W); ForwardBE is the same using RtE.
REQ-018 ForwardAD SHALL be (RsD!=0 & RegWriteM & RsD==WriteRegM); ForwardBD uses RtD.
REQ-019 lwstall SHALL be MemtoRegE & (RsD==WriteRegE | RtD==WriteRegE), ignoring register 0.
REQ-020 brstall SHALL be BranchD & ((RegWriteE & WriteRegE matches RsD/RtD) | (MemtoRegM & WriteRegM matches RsD/RtD)), ignoring register 0.
REQ-021 The FSM SHALL have the states RUN and MD_BUSY, plus an 8-bit down-counter cnt.
REQ-022 In RUN, MdStartE=1 SHALL move the FSM to MD_BUSY on the next edge, loading cnt with DIV_CYCLES if MdIsDivE=1, else MUL_CYCLES.
REQ-023 In MD_BUSY, cnt SHALL decrement each cycle; at cnt==1 the FSM SHALL return to RUN and MdDone SHALL be 1 for that cycle, giving exactly N cycles in MD_BUSY.
REQ-024 In MD_BUSY, the block SHALL drive MdBusy=1, StallF=StallD=1, FlushE=1 and FlushD=0, regardless of all hazard inputs.
REQ-025 In RUN, StallF=StallD=FlushE SHALL equal lwstall|brstall, and FlushD SHALL equal PCSrcD & ~StallD.
REQ-026 MdStartE while in MD_BUSY SHALL be ignored, because Execute holds a bubble in that state.
REQ-027 Load-use/branch stall, taken-branch flush and MD_BUSY entry in the same cycle SHALL resolve with the stall winning: FlushD is suppressed and the FSM still enters MD_BUSY.
REQ-028 All outputs except MdDone and MdBusy SHALL be combinational from the inputs and the state, with zero latency.

Reset
REQ-029 Asserting rst SHALL immediately force the state to RUN, cnt=0, MdBusy=0 and MdDone=0, including mid-MD_BUSY, which abandons the operation without an MdDone pulse.
REQ-030 While rst=1, StallF, StallD, FlushD and FlushE SHALL be 0 and all Forward outputs SHALL be 0.

Configuration
REQ-031 With PIPE_CTRL_PERF_EN defined, the block SHALL add the output StallCnt (out, 32 bits), which increments on every cycle with StallD=1, wraps from 0xFFFFFFFF to 0, and is cleared by rst.
REQ-032 Without PIPE_CTRL_PERF_EN, StallCnt and its counter SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-033 The package pipe_pkg SHALL hold the state enum (RUN, MD_BUSY), the forward-select constants (FWD_RF=00, FWD_W=01, FWD_M=10) and the 5-bit register-index width.
REQ-034 The design SHALL use one sub-module, pipe_fwd, containing the purely combinational forwarding comparators (REQ-017, REQ-018); the FSM and the stall logic SHALL live in pipe_ctrl.

Verification
REQ-035 Test: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10; with RsE=0 instead -> ForwardAE=00.
REQ-036 Test: MemtoRegE=1, WriteRegE=8, RtD=8 -> StallF=StallD=FlushE=1 for exactly one cycle, then 0 once the load reaches M.
REQ-037 Test: BranchD=1, PCSrcD=1, no hazards -> FlushD=1, StallD=0; adding RegWriteE=1, WriteRegE=RsD=3 -> FlushD=0, StallD=1.
REQ-038 Test: MdStartE=1, MdIsDivE=0 (MUL_CYCLES=4) -> MdBusy=1 and StallD=1 for 4 cycles, MdDone=1 in the 4th, and RUN resumes on the 5th; with a divide, the same behaviour over 32 cycles.
REQ-039 Test: rst pulsed in the 10th cycle of a divide -> MdBusy=0 and all stalls 0 immediately, with no MdDone pulse.
REQ-040 Test (with PIPE_CTRL_PERF_EN): one divide (32 cycles) plus one load-use stall -> StallCnt=33.
